// File: rtl/ram16_pkg.sv
// Shared types for the 16-bit RAM reader slice.
//   DATA_W         : RAM / stream word width
//   word_t         : one RAM word
//   reader_state_t : burst controller states
package ram16_pkg;

   localparam int unsigned DATA_W = 16;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } reader_state_t;

endpackage

// File: rtl/ram16_skid_fifo.sv
// Two-entry FIFO sitting between the RAM read port and the output stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO, clears data)
//   push       : write push_data (ignored when full unless a pop happens in the same cycle)
//   push_data  : word to write
//   pop        : remove the head entry (ignored when empty)
//   count      : number of stored entries, 0..2
//   head       : oldest entry; holds its value until popped
module ram16_skid_fifo
   import ram16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        count,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] tail;
   logic              pop_ok;
   logic              push_ok;

   assign pop_ok  = pop & (count != 2'd0);
   assign push_ok = push & ((count != 2'd2) | pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               // count is 1 or 2 here; the new word lands behind whatever remains
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ram16_stream_reader.sv
// Burst reader for the 16-bit simple dual-port RAM (registered read, 1-cycle
// latency, no read enable). A start command walks i_length words from
// i_start_address, wrapping modulo DEPTH, and streams them out on a
// valid/ready interface with full backpressure.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : start command, honoured only while o_busy=0
//   i_start_address  : first RAM address of the burst
//   i_length         : words to read, 0..DEPTH (larger values clamp to DEPTH)
//   o_busy           : burst in progress
//   o_done           : one-cycle pulse after the final beat is accepted
//   o_read_address   : registered RAM read address
//   i_read_value     : RAM data for the address presented one cycle earlier
//   o_data, o_valid  : stream data / valid (FIFO head)
//   i_ready          : stream ready from downstream
//   o_last           : final beat of the burst, qualified by o_valid
module ram16_stream_reader
   import ram16_pkg::*;
#(
   parameter  int unsigned DEPTH = 1024,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [AW-1:0]     i_start_address,
   input  logic [LW-1:0]     i_length,
   output logic              o_busy,
   output logic              o_done,
   output logic [AW-1:0]     o_read_address,
   input  logic [DATA_W-1:0] i_read_value,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_last
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [LW-1:0] MAX_LEN   = LW'(DEPTH);

   reader_state_t     state;
   reader_state_t     state_next;

   logic [AW-1:0]     addr;
   logic [AW-1:0]     addr_inc;
   logic              issue;
   logic              inflight;
   logic [LW-1:0]     to_issue;
   logic [LW-1:0]     to_send;
   logic [LW-1:0]     len_eff;
   logic              busy;
   logic              done;

   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] head;
   logic              valid;
   logic              pop;
   logic              push;
   logic              credit_ok;

   logic              start_burst;
   logic              start_empty;
   logic              advance;
   logic              finish;

   assign valid = (fifo_count != 2'd0);
   assign pop   = valid & i_ready;

   // The in-flight word may wait on the RAM output while the FIFO is full:
   // the address only moves on after a push is guaranteed, so the RAM keeps
   // re-reading the same location and i_read_value stays valid until captured.
   assign push = inflight & ((fifo_count != 2'd2) | pop);

   assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

   assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + AW'(1);
   assign len_eff  = (i_length > MAX_LEN) ? MAX_LEN : i_length;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start_burst = 1'b0;
      start_empty = 1'b0;
      advance     = 1'b0;
      finish      = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               if (len_eff != '0) begin
                  start_burst = 1'b1;
                  state_next  = (len_eff == LW'(1)) ? DRAIN : RUN;
               end else begin
                  start_empty = 1'b1;
               end
            end
         end
         RUN: begin
            if (credit_ok) begin
               advance = 1'b1;
               if (to_issue == LW'(1)) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (to_send == LW'(1))) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr     <= '0;
         issue    <= 1'b0;
         inflight <= 1'b0;
         to_issue <= '0;
         to_send  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= start_empty | finish;
         issue    <= start_burst | advance;
         inflight <= issue | (inflight & ~push);
         if (start_burst) begin
            addr     <= i_start_address;
            to_issue <= len_eff - LW'(1);
            to_send  <= len_eff;
            busy     <= 1'b1;
         end else begin
            if (advance) begin
               addr     <= addr_inc;
               to_issue <= to_issue - LW'(1);
            end
            if (pop)    to_send <= to_send - LW'(1);
            if (finish) busy    <= 1'b0;
         end
      end
   end

   ram16_skid_fifo u_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (push),
      .push_data (i_read_value),
      .pop       (pop),
      .count     (fifo_count),
      .head      (head)
   );

   assign o_busy         = busy;
   assign o_done         = done;
   assign o_read_address = addr;
   assign o_data         = head;
   assign o_valid        = valid;
   assign o_last         = valid & (to_send == LW'(1));

endmodule

// File: tb/tb_ram16_stream_reader.sv
module tb_ram16_stream_reader;
   import ram16_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned LW    = 5;

   logic          clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_start_address = '0;
   logic [LW-1:0] i_length = '0;
   logic          o_busy;
   logic          o_done;
   logic [AW-1:0] o_read_address;
   word_t         i_read_value = '0;
   word_t         o_data;
   logic          o_valid;
   logic          i_ready = 1'b1;
   logic          o_last;

   always #5 clk = ~clk;

   ram16_stream_reader #(.DEPTH(DEPTH)) dut (
      .i_clk           (clk),
      .i_rst_n         (i_rst_n),
      .i_start         (i_start),
      .i_start_address (i_start_address),
      .i_length        (i_length),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_read_address  (o_read_address),
      .i_read_value    (i_read_value),
      .o_data          (o_data),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_last          (o_last)
   );

   // RAM: registered read port, 1-cycle latency
   word_t mem [DEPTH];
   always @(posedge clk) i_read_value <= mem[o_read_address];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard (negedge) ----------------
   word_t         expq[$];
   logic [AW-1:0] addr_log[$];
   bit            model_busy = 0;
   bit            done_due = 0;
   bit            first_pending = 0;
   bit            full_rate = 0;
   bit            prev_stall = 0;
   word_t         prev_data = '0;
   int unsigned   negcnt = 0;
   int unsigned   start_n = 0;
   int unsigned   burst_addr = 0;
   int unsigned   burst_len = 0;
   int unsigned   beats = 0;
   int unsigned   rmode = 0;

   always @(negedge clk) begin
      bit          busy_next;
      bit          done_next;
      int unsigned eff;
      word_t       w;
      negcnt++;
      if (!i_rst_n) begin
         check("reset_outs", {o_busy, o_done, o_valid, o_last, o_read_address, o_data}, '0);
         expq.delete();
         addr_log.delete();
         model_busy    = 0;
         done_due      = 0;
         first_pending = 0;
         prev_stall    = 0;
         beats         = 0;
      end else begin
         check("done", o_done, done_due);
         check("busy", o_busy, model_busy);
         if (!model_busy) check("idle_valid", o_valid, 0);
         if (prev_stall) check("stall_hold", {o_valid, o_data}, {1'b1, prev_data});
         if (model_busy && (addr_log.size() == 0 || addr_log[$] != o_read_address))
            addr_log.push_back(o_read_address);
         if (first_pending && o_valid) begin
            check("latency", negcnt - start_n, 3);
            first_pending = 0;
         end else if (model_busy && full_rate && !first_pending && expq.size() > 0) begin
            check("throughput", o_valid, 1);
         end
         busy_next = model_busy;
         done_next = 0;
         if (o_valid && i_ready) begin
            if (expq.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               check("beat_data", o_data, expq[0]);
               check("beat_last", o_last, expq.size() == 1);
               w = expq.pop_front();
               beats++;
               if (expq.size() == 0) begin
                  done_next = 1;
                  busy_next = 0;
                  check("addr_count", addr_log.size(), burst_len);
                  for (int i = 0; i < addr_log.size() && i < burst_len; i++)
                     check("addr_seq", addr_log[i], (burst_addr + i) % DEPTH);
               end
            end
         end
         if (i_start && !model_busy) begin
            eff = (i_length > DEPTH) ? DEPTH : i_length;
            if (eff == 0) begin
               done_next = 1;
            end else begin
               busy_next     = 1;
               burst_addr    = i_start_address;
               burst_len     = eff;
               first_pending = 1;
               full_rate     = (rmode == 0);
               start_n       = negcnt;
               beats         = 0;
               addr_log.delete();
               for (int i = 0; i < eff; i++) expq.push_back(mem[(burst_addr + i) % DEPTH]);
            end
         end
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
         model_busy = busy_next;
         done_due   = done_next;
      end
   end

   // ---------------- ready generator ----------------
   initial begin
      int unsigned ph;
      bit pat [6];
      pat = '{1, 0, 0, 1, 0, 1};
      ph  = 0;
      forever begin
         @(posedge clk);
         #2;
         case (rmode)
            0:       i_ready = 1'b1;
            1:       begin i_ready = pat[ph]; ph = (ph + 1) % 6; end
            default: i_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_burst(input int unsigned addr, input int unsigned len);
      i_start         = 1'b1;
      i_start_address = AW'(addr);
      i_length        = LW'(len);
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done();
      int unsigned c;
      c = 0;
      while (!o_done && c < 400) begin @(posedge clk); #1; c++; end
      if (!o_done) check("done_timeout", 0, 1);
   endtask

   task automatic run(input int unsigned addr, input int unsigned len);
      start_burst(addr, len);
      wait_done();
   endtask

   task automatic wait_beats(input int unsigned n);
      int unsigned c;
      c = 0;
      while (beats < n && c < 100) begin @(posedge clk); #1; c++; end
      if (beats < n) check("beat_timeout", beats, n);
   endtask

   initial begin
      int unsigned a;
      int unsigned l;
      for (int i = 0; i < DEPTH; i++) mem[i] = word_t'(16'h100 + i);
      repeat (3) @(posedge clk);
      #1 i_rst_n = 1'b1;
      idle(1);

      run(3, 5);
      idle(2);
      run(14, 4);
      rmode = 1;
      run(0, 6);
      rmode = 0;
      idle(1);
      run(7, 0);
      idle(1);
      start_burst(2, 8);
      start_burst(9, 3);
      wait_done();
      idle(2);
      run(10, 3);
      run(12, 2);
      idle(1);
      run(15, 1);
      run(4, 16);
      rmode = 2;
      run(6, 20);
      rmode = 0;
      idle(2);
      start_burst(5, 8);
      wait_beats(2);
      i_rst_n = 1'b0;
      @(posedge clk); #1;
      i_rst_n = 1'b1;
      idle(3);
      run(1, 3);

      for (int b = 0; b < 30; b++) begin
         rmode = $urandom_range(0, 2);
         for (int i = 0; i < DEPTH; i++) mem[i] = word_t'($urandom);
         a = $urandom_range(0, DEPTH - 1);
         l = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
         start_burst(a, l);
         if (o_busy && $urandom_range(0, 2) == 0)
            start_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 16));
         wait_done();
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
      end
      rmode = 0;
      idle(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
